// File: rtl/sim_trace_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : sim_trace_monitor_if
// Description : Probe, control-state and trace read-port bundle between the
//               core under observation and sim_trace_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface sim_trace_monitor_if #(
  parameter int WIDTH   = 64,
  parameter int NCH     = 8,
  parameter int STATE_W = 5,
  parameter int CNT_W   = 16
);
  localparam int c_sel_w   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int c_entry_w = CNT_W + STATE_W + WIDTH;

  logic [STATE_W-1:0]   state_i;
  logic [NCH*WIDTH-1:0] probe_i;
  logic [c_sel_w-1:0]   sel_ch_i;
  logic                 rd_en_i;
  logic [c_entry_w-1:0] rd_data_o;
  logic                 rd_valid_o;
  logic                 empty_o;
  logic                 full_o;
  logic                 overflow_o;
  logic                 done_o;
  logic                 hang_o;
  logic [CNT_W-1:0]     cycle_o;

  // Driver side: the core / bench feeding probes and reading the trace
  modport master (
    output state_i, probe_i, sel_ch_i, rd_en_i,
    input  rd_data_o, rd_valid_o, empty_o, full_o, overflow_o, done_o, hang_o, cycle_o
  );

  // Monitor side
  modport slave (
    input  state_i, probe_i, sel_ch_i, rd_en_i,
    output rd_data_o, rd_valid_o, empty_o, full_o, overflow_o, done_o, hang_o, cycle_o
  );
endinterface
`default_nettype wire

// File: rtl/sim_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : sim_trace_monitor
// Description : Run-length counter, hang detector and state-change trace
//               buffer for the multicycle core. Each control-state change
//               logs {timestamp, state, selected probe} into a FIFO that is
//               drained through a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module sim_trace_monitor #(
  parameter int WIDTH      = 64,
  parameter int NCH        = 8,
  parameter int STATE_W    = 5,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 128,
  parameter int HANG_LIMIT = 32,
  parameter int MODE       = 0
) (
  input wire logic          clk,
  input wire logic          reset,
  sim_trace_monitor_if.slave mon
);
  localparam int c_sel_w   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int c_ptr_w   = $clog2(DEPTH);
  localparam int c_occ_w   = c_ptr_w + 1;
  localparam int c_stb_w   = $clog2(HANG_LIMIT + 1);
  localparam int c_entry_w = CNT_W + STATE_W + WIDTH;

  localparam logic [CNT_W-1:0]   c_last_cycle = CNT_W'(MAX_CYCLES - 1);
  localparam logic [c_stb_w-1:0] c_hang_lim   = c_stb_w'(HANG_LIMIT);
  localparam logic [c_occ_w-1:0] c_depth      = c_occ_w'(DEPTH);

  logic [CNT_W-1:0]     cycle_q, cycle_d;
  logic                 done_q, done_d;
  logic [STATE_W-1:0]   prev_state_q;
  logic                 prev_valid_q;
  logic [c_stb_w-1:0]   stable_q, stable_d;
  logic                 hang_q, hang_d;

  logic [c_entry_w-1:0] mem_q [DEPTH];
  logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_occ_w-1:0]   occ_q, occ_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 ovf_q, ovf_d;
  logic [c_entry_w-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;

  logic [WIDTH-1:0]     w_probe;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_wr;

  // Probe channel mux; selections with no matching channel capture zero
  always_comb begin
    w_probe = '0;
    for (int k = 0; k < NCH; k++) begin
      if (mon.sel_ch_i == c_sel_w'(k)) w_probe = mon.probe_i[k*WIDTH +: WIDTH];
    end
  end

  // Run length, capture decision and hang detection; all frozen once done
  always_comb begin
    cycle_d  = cycle_q;
    done_d   = done_q;
    stable_d = stable_q;
    hang_d   = hang_q;
    w_push   = 1'b0;
    if (!done_q) begin
      w_push = !prev_valid_q || (mon.state_i != prev_state_q);
      if (cycle_q == c_last_cycle) done_d = 1'b1;
      else                         cycle_d = cycle_q + 1'b1;
      if (w_push)                       stable_d = '0;
      else if (stable_q != c_hang_lim)  stable_d = stable_q + 1'b1;
      if (stable_d == c_hang_lim) hang_d = 1'b1;
    end
  end

  // Trace FIFO bookkeeping; a pop frees a slot before the push is judged
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    ovf_d      = ovf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    w_wr       = 1'b0;
    w_pop      = mon.rd_en_i && !empty_q;
    if (w_pop) begin
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end
    if (w_push) begin
      if (w_pop || !full_q) begin
        w_wr     = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (!w_pop) occ_d = occ_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
        // Circular mode: the write slot is the oldest entry, so both pointers advance
        if (MODE != 0) begin
          w_wr     = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
    end else if (w_pop) begin
      occ_d = occ_q - 1'b1;
    end
    full_d  = (occ_d == c_depth);
    empty_d = (occ_d == '0);
  end

  // State register for counters, flags, pointers and the read port
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q      <= '0;
      done_q       <= 1'b0;
      prev_state_q <= '0;
      prev_valid_q <= 1'b0;
      stable_q     <= '0;
      hang_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      ovf_q        <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      cycle_q      <= cycle_d;
      done_q       <= done_d;
      prev_state_q <= mon.state_i;
      prev_valid_q <= 1'b1;
      stable_q     <= stable_d;
      hang_q       <= hang_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      ovf_q        <= ovf_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Trace storage, left unreset so it can map onto block/distributed RAM
  always_ff @(posedge clk) begin
    if (!reset && w_wr) mem_q[wr_ptr_q] <= {cycle_q, mon.state_i, w_probe};
  end

  assign mon.rd_data_o  = rd_data_q;
  assign mon.rd_valid_o = rd_valid_q;
  assign mon.empty_o    = empty_q;
  assign mon.full_o     = full_q;
  assign mon.overflow_o = ovf_q;
  assign mon.done_o     = done_q;
  assign mon.hang_o     = hang_q;
  assign mon.cycle_o    = cycle_q;
endmodule
`default_nettype wire

// File: doc/sim_trace_monitor.md
Name: sim_trace_monitor

Overview:
- Parametrised run-control and trace block that sits beside the multicycle core `principal` in simulation and FPGA bring-up builds.
- Counts cycles and ends the run after MAX_CYCLES (done flag).
- On every control-state change it logs a time-stamped snapshot of one selected probe channel into a FIFO trace buffer.
- Flags a hung state machine. Captured entries are drained through a read port.

Parameters:
- WIDTH, 64, width of each probe channel (datapath wire width)
- NCH, 8, number of probe channels (e.g. muxA, muxB, ALU out, ALUOut, PC, memdata, WD, S-type)
- STATE_W, 5, width of the control FSM state input
- DEPTH, 16, trace buffer entries (power of two, >=2)
- CNT_W, 16, cycle counter / timestamp width
- MAX_CYCLES, 128, run length in cycles (1..2^CNT_W-1)
- HANG_LIMIT, 32, consecutive unchanged-state cycles that flag a hang (>=1)
- MODE, 0, 0 = stop-on-full, 1 = circular overwrite-oldest

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- state_in  in  STATE_W  control FSM state (stateOut of the core)
- probe_in  in  NCH*WIDTH  packed probe channels, channel k at bits [k*WIDTH +: WIDTH]
- sel_ch  in  $clog2(NCH)  channel captured into the trace; values >= NCH capture zero
- rd_en  in  1  pop request
- rd_data  out  CNT_W+STATE_W+WIDTH  {timestamp, state, probe}
- rd_valid  out  1  rd_data valid, one-cycle pulse
- empty  out  1  buffer empty
- full  out  1  buffer holds DEPTH entries
- overflow  out  1  sticky, an entry was dropped (MODE 0) or overwritten (MODE 1)
- done  out  1  sticky, run length reached
- hang  out  1  sticky, state unchanged for HANG_LIMIT cycles
- cycle  out  CNT_W  current cycle count

Behaviour:
- Reset: synchronous, highest priority, also when asserted mid-run.
  - cycle=0, done=0, hang=0, overflow=0.
  - Buffer empty: empty=1, full=0. rd_valid=0, rd_data=0.
  - prev_valid=0, stable counter=0.
- Cycle counter: increments by 1 each cycle while done=0.
  - At the edge where cycle==MAX_CYCLES-1: done<=1 and cycle holds at MAX_CYCLES-1.
- Capture condition (evaluated each cycle with done=0): prev_valid==0 (first cycle out of reset) OR state_in != prev_state.
  - Entry = {cycle, state_in, probe_in[sel_ch]}, all sampled in that cycle.
  - prev_state<=state_in and prev_valid<=1 every cycle.
  - No capture once done=1.
- Hang detection:
  - Stable counter resets to 0 on capture; otherwise increments, saturating at HANG_LIMIT.
  - Stable counter reaches HANG_LIMIT -> hang<=1 (sticky).
  - The counter freezes when done=1.
- Read path: rd_en with empty=0 pops the oldest entry. rd_data is registered and valid next cycle with rd_valid=1.
  - rd_en with empty=1 is ignored (rd_valid=0, rd_data holds).
  - Reads remain allowed after done.
- Simultaneous push and pop: both performed and occupancy unchanged, including when full (no overwrite, no overflow).
- Full with push and no pop:
  - MODE 0: entry dropped, overflow<=1, buffer unchanged.
  - MODE 1: oldest entry discarded (read pointer advances), new entry written, overflow<=1, full stays 1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked 0..DEPTH; full = occupancy==DEPTH, empty = occupancy==0.
- Output timing: all outputs are registered; flags reflect state after the current edge.

Test Plan:
- Reset, then hold state_in=5'd0 for 40 cycles -> one entry {0,0,probe}; hang=1 at cycle 32 (first cycle with cycle==32); empty=0.
- state_in changes 0->1->2 on cycles 0,1,2, sel_ch=2, channel 2 = 64'hA5 -> pop three entries with timestamps 0,1,2, states 0,1,2, probe 64'hA5; rd_valid one cycle after each rd_en; empty=1 after the third.
- Run free with state toggling every cycle, MAX_CYCLES=128 -> done=1 after edge with cycle==127; cycle holds 127; no captures afterward.
- MODE 0, DEPTH=16, 20 state changes with no reads -> full=1, overflow=1, popped timestamps 0..15.
- MODE 1, same stimulus -> overflow=1, popped timestamps 4..19.
- Full buffer, rd_en and a state change in the same cycle -> occupancy stays 16, overflow stays 0, the oldest entry is returned. Assert reset mid-run -> all outputs return to reset values next edge.
